// File: rtl/arc4_pkg.sv
// ARC4 shared definitions: byte width, memory depth and the PRGA state encoding.
// Used by both the encrypt and decrypt blocks.
package arc4_pkg;

  localparam int BYTE_W    = 8;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    SI_RD,
    J_UPD,
    SJ_RD,
    SWAP_I,
    SWAP_J,
    PAD_RD,
    CT_WR
  } state_t;

endpackage

// File: rtl/arc4_encrypt.sv
// ARC4 PRGA encryptor: ct[0]=L, ct[k]=pt[k]^keystream[k], S permuted in place.
// Ports: clk, rst (sync, high), en/rdy start handshake, S/pt/ct memory buses
//   (all reads have one cycle of latency, writes take effect at the edge).
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  output logic  rdy,
  output addr_t s_addr,
  input  byte_t s_rddata,
  output byte_t s_wrdata,
  output logic  s_wren,
  output addr_t pt_addr,
  input  byte_t pt_rddata,
  output addr_t ct_addr,
  output byte_t ct_wrdata,
  output logic  ct_wren
);

  state_t state;
  state_t state_nxt;

  byte_t i;
  byte_t j;
  byte_t k;
  byte_t len;
  byte_t si;
  byte_t sj;
  byte_t ptb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = LEN_RD;
      LEN_RD:  state_nxt = LEN_WR;
      LEN_WR:  state_nxt = (pt_rddata == '0) ? IDLE : SI_RD;
      SI_RD:   state_nxt = J_UPD;
      J_UPD:   state_nxt = SJ_RD;
      SJ_RD:   state_nxt = SWAP_I;
      SWAP_I:  state_nxt = SWAP_J;
      SWAP_J:  state_nxt = PAD_RD;
      PAD_RD:  state_nxt = CT_WR;
      CT_WR:   state_nxt = (k == len) ? IDLE : SI_RD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state)
      IDLE: rdy = 1'b1;
      LEN_RD: pt_addr = '0;
      LEN_WR: begin
        ct_addr   = '0;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      SI_RD: s_addr = i;
      SJ_RD: s_addr = j;
      // When i==j both writes hit the same cell with si, so S[i] is unchanged.
      SWAP_I: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      SWAP_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        pt_addr  = k;
      end
      PAD_RD: s_addr = si + sj;
      CT_WR: begin
        ct_addr   = k;
        ct_wrdata = ptb ^ s_rddata;
        ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      len <= '0;
      si  <= '0;
      sj  <= '0;
      ptb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        LEN_WR: begin
          len <= pt_rddata;
          if (pt_rddata != '0) begin
            i <= 8'd1;
            k <= 8'd1;
          end
        end
        J_UPD: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        SWAP_I: sj  <= s_rddata;
        PAD_RD: ptb <= pt_rddata;
        // k stops at len (<=255) so neither k nor i can wrap.
        CT_WR: begin
          if (k != len) begin
            i <= i + 8'd1;
            k <= k + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt with behavioural S/pt/ct memories.
// Expected ciphertext comes from known RC4 vectors and hand derivation.
module tb_arc4_encrypt;
  import arc4_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  en  = 1'b0;
  logic  rdy;
  addr_t s_addr;
  byte_t s_rddata;
  byte_t s_wrdata;
  logic  s_wren;
  addr_t pt_addr;
  byte_t pt_rddata;
  addr_t ct_addr;
  byte_t ct_wrdata;
  logic  ct_wren;

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  byte_t s_mem  [MEM_DEPTH];
  byte_t s_init [MEM_DEPTH];
  byte_t pt_mem [MEM_DEPTH];
  byte_t ct_mem [MEM_DEPTH];
  byte_t orig   [MEM_DEPTH];
  logic  s_load = 1'b0;
  logic  ct_clr = 1'b0;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (s_load) s_mem <= s_init;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (ct_clr) ct_mem <= '{default: 8'hEE};
    else if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  int ct_wr_cnt = 0;
  int s_wr_cnt  = 0;
  int idle_bad  = 0;

  always @(negedge clk) begin
    if (ct_wren) ct_wr_cnt++;
    if (s_wren) s_wr_cnt++;
    if (!rst && rdy && (s_wren || ct_wren || s_addr != 0 ||
        pt_addr != 0 || ct_addr != 0 || s_wrdata != 0 ||
        ct_wrdata != 0))
      idle_bad++;
  end

  int checks   = 0;
  int failures = 0;

  byte_t exp_kv [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9,
                        8'h40, 8'hAF, 8'h0A, 8'hD3};
  string kv_pt = "Plaintext";

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ident();
    for (int x = 0; x < MEM_DEPTH; x++) s_init[x] = byte_t'(x);
    s_load = 1'b1;
    ct_clr = 1'b1;
    step();
    s_load = 1'b0;
    ct_clr = 1'b0;
  endtask

  task automatic load_ksa(input string key);
    byte_t jj;
    byte_t t;
    for (int x = 0; x < MEM_DEPTH; x++) s_init[x] = byte_t'(x);
    jj = 0;
    for (int x = 0; x < MEM_DEPTH; x++) begin
      jj = jj + s_init[x] + byte_t'(key[x % key.len()]);
      t = s_init[x];
      s_init[x] = s_init[jj];
      s_init[jj] = t;
    end
    s_load = 1'b1;
    ct_clr = 1'b1;
    step();
    s_load = 1'b0;
    ct_clr = 1'b0;
  endtask

  task automatic load_kv_pt();
    pt_mem[0] = 8'd9;
    for (int n = 0; n < 9; n++) pt_mem[n+1] = byte_t'(kv_pt[n]);
  endtask

  task automatic run(output int cyc);
    cyc = 0;
    en = 1'b1;
    step();
    en = 1'b0;
    while (!rdy && cyc < 5000) begin
      cyc++;
      step();
    end
    if (!rdy) begin
      failures++;
      $display("FAIL run_timeout rdy=%0b after %0d cycles", rdy, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy got=%0b exp=1", rdy);
    end
    checks++;
    if ({s_wren, ct_wren} !== 2'b00 ||
        {s_addr, pt_addr, ct_addr} !== 24'h0 ||
        {s_wrdata, ct_wrdata} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outs wren=%b%b addr=%h/%h/%h exp=0",
               s_wren, ct_wren, s_addr, pt_addr, ct_addr);
    end
    rst = 1'b0;
    en  = 1'b0;
    step();
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_en_ignored rdy=%0b exp=1", rdy);
    end
  endtask

  task automatic test_empty();
    int cyc, c0, s0;
    load_ident();
    pt_mem[0] = 8'h00;
    c0 = ct_wr_cnt;
    s0 = s_wr_cnt;
    run(cyc);
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL empty_latency got=%0d exp=2", cyc);
    end
    checks++;
    if (ct_mem[0] !== 8'h00) begin
      failures++;
      $display("FAIL empty_ct0 got=%h exp=00", ct_mem[0]);
    end
    checks++;
    if (ct_wr_cnt - c0 !== 1) begin
      failures++;
      $display("FAIL empty_ctwr got=%0d exp=1", ct_wr_cnt - c0);
    end
    checks++;
    if (s_wr_cnt - s0 !== 0) begin
      failures++;
      $display("FAIL empty_swr got=%0d exp=0", s_wr_cnt - s0);
    end
  endtask

  task automatic test_single();
    int cyc, bad;
    load_ident();
    pt_mem[0] = 8'h01;
    pt_mem[1] = 8'h00;
    run(cyc);
    checks++;
    if (cyc !== 9) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=9", cyc);
    end
    checks++;
    if ({ct_mem[0], ct_mem[1]} !== 16'h0102) begin
      failures++;
      $display("FAIL single_ct got=%h%h exp=0102", ct_mem[0], ct_mem[1]);
    end
    bad = 0;
    for (int x = 0; x < MEM_DEPTH; x++)
      if (s_mem[x] != byte_t'(x)) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL single_s_unchanged got=%0d bad exp=0", bad);
    end
  endtask

  task automatic test_known_vector();
    int cyc, s0;
    load_ksa("Key");
    load_kv_pt();
    s0 = s_wr_cnt;
    run(cyc);
    checks++;
    if (cyc !== 65) begin
      failures++;
      $display("FAIL kv_latency got=%0d exp=65", cyc);
    end
    checks++;
    if (s_wr_cnt - s0 !== 18) begin
      failures++;
      $display("FAIL kv_swr got=%0d exp=18", s_wr_cnt - s0);
    end
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (ct_mem[n+1] !== exp_kv[n]) begin
        failures++;
        $display("FAIL kv_ct%0d got=%h exp=%h", n + 1, ct_mem[n+1], exp_kv[n]);
      end
    end
  endtask

  task automatic test_en_ignored();
    int cyc;
    load_ksa("Key");
    load_kv_pt();
    cyc = 0;
    en = 1'b1;
    step();
    en = 1'b0;
    while (!rdy && cyc < 5000) begin
      cyc++;
      en = (cyc == 19);
      step();
    end
    en = 1'b0;
    checks++;
    if (cyc !== 65) begin
      failures++;
      $display("FAIL ign_latency got=%0d exp=65", cyc);
    end
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (ct_mem[n+1] !== exp_kv[n]) begin
        failures++;
        $display("FAIL ign_ct%0d got=%h exp=%h", n + 1, ct_mem[n+1], exp_kv[n]);
      end
    end
    step();
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL ign_no_restart rdy=%0b exp=1", rdy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, c0;
    load_ksa("Key");
    load_kv_pt();
    c0 = ct_wr_cnt;
    cyc = 0;
    en = 1'b1;
    step();
    en = 1'b0;
    while (cyc < 14) begin
      cyc++;
      if (cyc == 14) begin
        checks++;
        if (s_wren !== 1'b1 || rdy !== 1'b0) begin
          failures++;
          $display("FAIL mid_swapj s_wren=%0b rdy=%0b exp=1/0", s_wren, rdy);
        end
        rst = 1'b1;
      end
      step();
    end
    rst = 1'b0;
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL mid_rdy got=%0b exp=1", rdy);
    end
    repeat (10) step();
    checks++;
    if (ct_wr_cnt - c0 !== 2) begin
      failures++;
      $display("FAIL mid_ctwr got=%0d exp=2", ct_wr_cnt - c0);
    end
    load_ksa("Key");
    run(cyc);
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (ct_mem[n+1] !== exp_kv[n]) begin
        failures++;
        $display("FAIL mid_ct%0d got=%h exp=%h", n + 1, ct_mem[n+1], exp_kv[n]);
      end
    end
  endtask

  task automatic test_round_trip();
    int cyc, bad;
    load_ksa("Secret");
    pt_mem[0] = 8'd255;
    orig[0] = 8'd255;
    for (int n = 1; n < MEM_DEPTH; n++) begin
      pt_mem[n] = byte_t'($urandom);
      orig[n] = pt_mem[n];
    end
    run(cyc);
    checks++;
    if (cyc !== 1787) begin
      failures++;
      $display("FAIL rt_latency got=%0d exp=1787", cyc);
    end
    for (int n = 0; n < MEM_DEPTH; n++) pt_mem[n] = ct_mem[n];
    load_ksa("Secret");
    run(cyc);
    bad = 0;
    for (int n = 0; n < MEM_DEPTH; n++)
      if (ct_mem[n] !== orig[n]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rt_recover got=%0d bad bytes exp=0", bad);
    end
  endtask

  task automatic test_idle_quiet();
    checks++;
    if (idle_bad !== 0) begin
      failures++;
      $display("FAIL idle_quiet got=%0d active idle cycles exp=0", idle_bad);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_known_vector();
    test_en_ignored();
    test_reset_mid();
    test_round_trip();
    test_idle_quiet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
